// File: rtl/fan_countdown_timer.sv
// fan_countdown_timer: two-digit BCD countdown with preset, pause/resume/cancel and fan_off on expiry
module fan_countdown_timer #(
  parameter int          TICK_DIV    = 1000,
  parameter logic [7:0]  DEFAULT_BCD = 8'h30,
  parameter logic [7:0]  MAX_BCD     = 8'h99,
  parameter logic [7:0]  MIN_BCD     = 8'h01
) (
  input  logic       clk_1kHz,
  input  logic       rst,
  input  logic       inc_p,
  input  logic       dec_p,
  input  logic       start_p,
  output logic [7:0] preset_bcd,
  output logic [7:0] remain_bcd,
  output logic [1:0] state,
  output logic       running,
  output logic       fan_off,
  output logic       tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  logic [1:0]    state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [7:0]    preset_nx, remain_nx;
  logic          step, adj;
  function automatic logic [7:0] bcd_up(input logic [7:0] x);
    return x[3:0] == 4'd9 ? {x[7:4] + 4'd1, 4'd0} : {x[7:4], x[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dn(input logic [7:0] x);
    return x[3:0] == 4'd0 ? {x[7:4] - 4'd1, 4'd9} : {x[7:4], x[3:0] - 4'd1};
  endfunction
  assign step = state == RUN && presc == PW'(TICK_DIV - 1);
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      state      <= IDLE;
      preset_bcd <= DEFAULT_BCD;
      remain_bcd <= DEFAULT_BCD;
      presc      <= '0;
      running    <= 1'b0;
      fan_off    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state      <= state_nx;
      preset_bcd <= preset_nx;
      remain_bcd <= remain_nx;
      presc      <= presc_nx;
      running    <= state_nx == RUN;
      fan_off    <= state_nx == DONE;
      tick       <= step;
    end
  end
  // reaching 00 on a step overrides a simultaneous pause request
  always_comb begin
    state_nx = state == IDLE  ? (start_p ? RUN : IDLE) :
               state == RUN   ? (step && remain_bcd == 8'h01 ? DONE : start_p ? PAUSE : RUN) :
               state == PAUSE ? (start_p ? RUN : dec_p ? IDLE : PAUSE) :
                                (start_p ? IDLE : DONE);
  end
  always_comb begin
    adj       = state == IDLE && !start_p && (inc_p ^ dec_p);
    preset_nx = !adj ? preset_bcd :
                inc_p ? (preset_bcd == MAX_BCD ? preset_bcd : bcd_up(preset_bcd)) :
                        (preset_bcd == MIN_BCD ? preset_bcd : bcd_dn(preset_bcd));
    remain_nx = state_nx == DONE ? 8'h00 :
                step ? bcd_dn(remain_bcd) :
                state_nx == IDLE || state == IDLE ? preset_nx : remain_bcd;
    presc_nx  = state == RUN ? (step ? '0 : presc + 1'b1) :
                state == PAUSE && state_nx != IDLE ? presc : '0;
  end
endmodule

// File: tb/tb_fan_countdown_timer.sv
// tb_fan_countdown_timer: directed and random stimulus checked against an integer-seconds model
module tb_fan_countdown_timer;
  localparam int TD = 4;
  logic clk = 1'b0, rst = 1'b1, inc_p = 1'b0, dec_p = 1'b0, start_p = 1'b0;
  logic [7:0] preset_bcd, remain_bcd;
  logic [1:0] state;
  logic running, fan_off, tick;
  int checks = 0, errors = 0;
  bit en = 1'b0;
  int m_st, m_pre, m_rem, m_ph;
  bit m_tick, m_run, m_fan;
  fan_countdown_timer #(.TICK_DIV(TD)) dut (
    .clk_1kHz(clk), .rst(rst), .inc_p(inc_p), .dec_p(dec_p), .start_p(start_p),
    .preset_bcd(preset_bcd), .remain_bcd(remain_bcd), .state(state),
    .running(running), .fan_off(fan_off), .tick(tick)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // model: state 0 idle / 1 run / 2 pause / 3 done, times held as plain seconds
  always @(posedge clk) begin
    bit st;
    if (rst) begin
      m_st = 0; m_pre = 30; m_rem = 30; m_ph = 0; m_tick = 0;
    end else begin
      st = m_st == 1 && m_ph == TD - 1;
      case (m_st)
        0: if (start_p) begin
             m_st = 1; m_rem = m_pre; m_ph = 0;
           end else begin
             if (inc_p && !dec_p && m_pre < 99) m_pre++;
             if (dec_p && !inc_p && m_pre > 1) m_pre--;
             m_rem = m_pre;
           end
        1: begin
             m_ph = st ? 0 : m_ph + 1;
             if (st) m_rem--;
             if (st && m_rem == 0) m_st = 3;
             else if (start_p) m_st = 2;
           end
        2: if (start_p) m_st = 1;
           else if (dec_p) begin
             m_st = 0; m_rem = m_pre; m_ph = 0;
           end
        default: if (start_p) begin
             m_st = 0; m_rem = m_pre;
           end
      endcase
      m_tick = st;
    end
    m_run = m_st == 1;
    m_fan = m_st == 3;
  end
  always @(negedge clk) if (en) begin
    chk("m_state", {6'd0, state}, 8'(m_st));
    chk("m_preset", preset_bcd, to_bcd(m_pre));
    chk("m_remain", remain_bcd, to_bcd(m_rem));
    chk("m_running", {7'd0, running}, {7'd0, m_run});
    chk("m_fan_off", {7'd0, fan_off}, {7'd0, m_fan});
    chk("m_tick", {7'd0, tick}, {7'd0, m_tick});
  end
  task automatic pulse(input bit i, input bit d, input bit s);
    inc_p = i; dec_p = d; start_p = s;
    @(posedge clk); #1;
    inc_p = 0; dec_p = 0; start_p = 0;
  endtask
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    @(posedge clk); #1;
    rst = 0; en = 1;
    chk("rst_state", {6'd0, state}, 8'h00);
    chk("rst_preset", preset_bcd, 8'h30);
    chk("rst_remain", remain_bcd, 8'h30);
    chk("rst_fan_off", {7'd0, fan_off}, 8'h00);
    chk("rst_running", {7'd0, running}, 8'h00);
    repeat (21) pulse(0, 1, 0);
    chk("preset_09", preset_bcd, 8'h09);
    pulse(1, 0, 0);
    chk("preset_carry", preset_bcd, 8'h10);
    chk("remain_tracks", remain_bcd, 8'h10);
    repeat (89) pulse(1, 0, 0);
    chk("preset_99", preset_bcd, 8'h99);
    pulse(1, 0, 0);
    chk("sat_max", preset_bcd, 8'h99);
    repeat (98) pulse(0, 1, 0);
    chk("preset_01", preset_bcd, 8'h01);
    pulse(0, 1, 0);
    chk("sat_min", preset_bcd, 8'h01);
    pulse(1, 1, 0);
    chk("inc_dec_same", preset_bcd, 8'h01);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("run_started", {7'd0, running}, 8'h01);
    idle_cycles(3);
    chk("no_tick_early", {7'd0, tick}, 8'h00);
    idle_cycles(1);
    chk("tick1", {7'd0, tick}, 8'h01);
    chk("remain_01", remain_bcd, 8'h01);
    idle_cycles(4);
    chk("remain_00", remain_bcd, 8'h00);
    chk("done_state", {6'd0, state}, 8'h03);
    chk("done_fan", {7'd0, fan_off}, 8'h01);
    pulse(1, 0, 0);
    chk("done_ign_inc", preset_bcd, 8'h02);
    pulse(0, 0, 1);
    chk("ack_state", {6'd0, state}, 8'h00);
    chk("ack_fan", {7'd0, fan_off}, 8'h00);
    chk("ack_remain", remain_bcd, 8'h02);
    repeat (8) pulse(1, 0, 0);
    pulse(0, 0, 1);
    idle_cycles(4);
    chk("step_09", remain_bcd, 8'h09);
    idle_cycles(1);
    pulse(0, 0, 1);
    chk("paused", {6'd0, state}, 8'h02);
    idle_cycles(20);
    chk("pause_frozen", remain_bcd, 8'h09);
    chk("pause_held", {6'd0, state}, 8'h02);
    pulse(0, 0, 1);
    idle_cycles(1);
    chk("resume_no_tick", {7'd0, tick}, 8'h00);
    idle_cycles(1);
    chk("resume_tick", {7'd0, tick}, 8'h01);
    chk("resume_08", remain_bcd, 8'h08);
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    chk("cancel_state", {6'd0, state}, 8'h00);
    chk("cancel_remain", remain_bcd, 8'h10);
    pulse(0, 0, 1);
    pulse(1, 1, 1);
    chk("all3_pause", {6'd0, state}, 8'h02);
    chk("all3_preset", preset_bcd, 8'h10);
    pulse(0, 0, 1);
    for (int i = 0; i < 200 && !fan_off; i++) idle_cycles(1);
    chk("reach_done", {7'd0, fan_off}, 8'h01);
    pulse(0, 0, 1);
    chk("ack2_fan", {7'd0, fan_off}, 8'h00);
    chk("ack2_remain", remain_bcd, 8'h10);
    repeat (5) pulse(0, 1, 0);
    pulse(0, 0, 1);
    chk("run_05", remain_bcd, 8'h05);
    rst = 1;
    idle_cycles(1);
    rst = 0;
    chk("mid_rst_state", {6'd0, state}, 8'h00);
    chk("mid_rst_remain", remain_bcd, 8'h30);
    chk("mid_rst_preset", preset_bcd, 8'h30);
    chk("mid_rst_tick", {7'd0, tick}, 8'h00);
    pulse(0, 0, 1);
    idle_cycles(4);
    chk("post_rst_tick", {7'd0, tick}, 8'h01);
    chk("post_rst_29", remain_bcd, 8'h29);
    for (int i = 0; i < 4000; i++) begin
      inc_p = $urandom_range(3) == 0;
      dec_p = $urandom_range(3) == 0;
      start_p = $urandom_range(11) == 0;
      rst = $urandom_range(599) == 0;
      @(posedge clk); #1;
    end
    inc_p = 0; dec_p = 0; start_p = 0; rst = 0;
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
